fechadura_setup: RTL and testbench
==================================

// Module: fechadura_setup
// PURPOSE
//   Configuration-menu controller of the digital door lock (fechadura).
//   Activated by the operational controller via setup_on (after master password + '*').
//   Walks the user through configuration fields entered on the keypad and drives the
//   setup display packet. Returns the new configuration with a one-cycle data_setup_ok pulse.
//   Sits between the keypad decoder, the operational FSM and the display mux.
// PARAMETERS
//   T_MIN  5   minimum accepted time value (seconds)
//   T_MAX  60  maximum accepted time value (seconds)
// PORTS
//   clk             in   1     system clock, all state on rising edge
//   rst             in   1     reset, asynchronous, active-high
//   setup_on        in   1     held high by operational FSM while setup mode is granted
//   digitos_value   in   80    senhaPac_t: digits[19:0] x 4b; digits[0] newest; 0xF = empty
//   digitos_valid   in   1     1-cycle strobe: digitos_value updated by one key
//   display_en      out  1     1 while menu is active (selects setup packet in display mux)
//   bcd_pac         out  24   bcdPac_t: BCD5..BCD0, 4b each
//   data_setup_new  out  setupPac_t  bip_on(1), bip_time(7), tranc_time(7), senha_master(senhaPac_t)
//   data_setup_ok   out  1     1-cycle pulse: data_setup_new is valid, setup finished
// BEHAVIOUR
//   Reset: state IDLE; display_en=0; bcd_pac=0 (all fields 0); data_setup_ok=0;
//     data_setup_new = {bip_on=1, bip_time=5, tranc_time=5, senha_master=1,2,3,4 then 0xF}.
//   Outputs are registered; response visible the cycle after the sampled strobe.
//   Keys: 0-9 digits, 0xA='*' (confirm), 0xB='#' (exit). Only strobes whose digits[0] is
//     0xA or 0xB are acted upon; digit strobes are ignored (keypad buffers them).
//   Field value on '*': tens=digits[2], units=digits[1]; 0xF counts as 0.
//   States: IDLE -> S_BIP(1) -> S_BTIME(2) -> S_TTIME(3) -> S_MASTER(4) -> DONE.
//   IDLE: display_en=0, bcd_pac=0. Cycle setup_on=1 seen: copy data_setup_new into the
//     working copy, go S_BIP.
//   Active states: display_en=1; BCD5 = step number (1..4); BCD4..BCD2 = 0xF;
//     steps 1-3: BCD1:BCD0 = working value in decimal; step 4: BCD1=BCD0=0xF.
//   '*' in S_BIP: value 0 or 1 -> store bip_on, advance; else stay, no change.
//   '*' in S_BTIME/S_TTIME: T_MIN<=value<=T_MAX -> store, advance; else stay.
//   '*' in S_MASTER: digits[1..n] up to first 0xF, 4..12 digits -> new senha_master
//     stored oldest-first followed by 0xF, advance to DONE; otherwise stay.
//   '#' in any active state: go DONE keeping fields already confirmed.
//   DONE: load working copy into data_setup_new, data_setup_ok=1 for exactly one cycle,
//     then IDLE (display_en=0, bcd_pac=0).
//   setup_on dropping while active: abort to IDLE, no ok pulse, data_setup_new unchanged.
//   setup_on held high after DONE: no re-entry until setup_on seen low.
//   Simultaneous strobe and setup_on fall: abort wins.
//   Reset mid-menu: immediate IDLE with defaults above.
// TESTING
//   Reset, setup_on=0 -> display_en=0, bcd_pac.BCD5=0, data_setup_ok=0.
//   Raise setup_on -> next cycle display_en=1, BCD5=1, BCD0=1 (default bip_on).
//   In step 1 send '#' -> one-cycle data_setup_ok, config unchanged, display_en=0.
//   Keys 0,*,3,0,*,7,0,*: bip_on=0, bip_time=30; 70 rejected, BCD5 stays 3.
//   Full pass keys 1,* 1,0,* 2,0,* 9,8,7,6,* -> ok pulse; bip_time=10, tranc_time=20,
//     senha_master=9,8,7,6.
//   Drop setup_on in step 2 -> IDLE, no ok pulse; assert rst mid-menu -> defaults restored.

Source files
------------

// File: rtl/fechadura_setup.sv
// Configuration menu of the door lock: walks the user through beep, beep time,
// lock time and master password, then hands the new configuration back with a one-cycle ok.
module fechadura_setup #(
  parameter int T_MIN = 5,
  parameter int T_MAX = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        setup_on,
  input  logic [79:0] digitos_value,
  input  logic        digitos_valid,
  output logic        display_en,
  output logic [23:0] bcd_pac,
  output logic [94:0] data_setup_new,
  output logic        data_setup_ok
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    S_BIP    = 3'd1,
    S_BTIME  = 3'd2,
    S_TTIME  = 3'd3,
    S_MASTER = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [3:0]  KEY_CONFIRM = 4'hA;
  localparam logic [3:0]  KEY_EXIT    = 4'hB;
  localparam logic [3:0]  EMPTY       = 4'hF;
  localparam logic [94:0] CFG_DEFAULT = {1'b1, 7'd5, 7'd5, 80'hFFFF_FFFF_FFFF_FFFF_4321};

  state_t      state_r, state_nxt_s;
  logic        armed_r;
  logic        bip_r, bip_nxt_s;
  logic [6:0]  btime_r, btime_nxt_s, ttime_r, ttime_nxt_s;
  logic [79:0] senha_r, senha_nxt_s;
  logic [3:0]  key_s;
  logic [6:0]  value_s;
  logic        time_ok_s;
  logic [4:0]  pw_len_s;
  logic        pw_found_s;
  logic [79:0] pw_s;

  function automatic logic [3:0] digit_val(input logic [3:0] d);
    if (d > 4'd9) return 4'd0;
    else return d;
  endfunction

  function automatic logic [23:0] make_bcd(input state_t st, input logic bip,
                                           input logic [6:0] bt, input logic [6:0] tt);
    logic [6:0] v;
    logic [3:0] tens, units;
    case (st)
      S_BIP:   v = {6'd0, bip};
      S_BTIME: v = bt;
      S_TTIME: v = tt;
      default: v = 7'd0;
    endcase
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    case (st)
      S_BIP, S_BTIME, S_TTIME: make_bcd = {1'b0, st, 12'hFFF, tens, units};
      S_MASTER:                make_bcd = {4'h4, 20'hFFFFF};
      default:                 make_bcd = 24'h000000;
    endcase
  endfunction

  // Decode the keypad buffer: action key, two-digit field value, password length and order
  always_comb begin
    key_s      = digitos_value[3:0];
    value_s    = 7'(digit_val(digitos_value[11:8])) * 7'd10 + 7'(digit_val(digitos_value[7:4]));
    time_ok_s  = (int'(value_s) >= T_MIN) && (int'(value_s) <= T_MAX);
    pw_len_s   = 5'd19;
    pw_found_s = 1'b0;
    for (int i = 1; i < 20; i++) begin
      if (!pw_found_s && digitos_value[i*4 +: 4] == EMPTY) begin
        pw_len_s   = 5'(i - 1);
        pw_found_s = 1'b1;
      end else begin
        pw_found_s = pw_found_s;
      end
    end
    // digits[n] is the oldest key, so it becomes password digit 0
    for (int i = 0; i < 20; i++) begin
      if (5'(i) < pw_len_s) pw_s[i*4 +: 4] = digitos_value[{pw_len_s - 5'(i), 2'b00} +: 4];
      else pw_s[i*4 +: 4] = EMPTY;
    end
  end

  // Menu transitions and working-copy updates
  always_comb begin
    state_nxt_s = state_r;
    bip_nxt_s   = bip_r;
    btime_nxt_s = btime_r;
    ttime_nxt_s = ttime_r;
    senha_nxt_s = senha_r;
    case (state_r)
      IDLE: begin
        if (setup_on && armed_r) begin
          state_nxt_s = S_BIP;
          {bip_nxt_s, btime_nxt_s, ttime_nxt_s, senha_nxt_s} = data_setup_new;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      S_BIP, S_BTIME, S_TTIME, S_MASTER: begin
        if (!setup_on) begin
          state_nxt_s = IDLE;
        end else if (digitos_valid && key_s == KEY_EXIT) begin
          state_nxt_s = DONE;
        end else if (digitos_valid && key_s == KEY_CONFIRM) begin
          case (state_r)
            S_BIP: begin
              if (value_s <= 7'd1) begin
                bip_nxt_s   = value_s[0];
                state_nxt_s = S_BTIME;
              end else begin
                state_nxt_s = S_BIP;
              end
            end
            S_BTIME: begin
              if (time_ok_s) begin
                btime_nxt_s = value_s;
                state_nxt_s = S_TTIME;
              end else begin
                state_nxt_s = S_BTIME;
              end
            end
            S_TTIME: begin
              if (time_ok_s) begin
                ttime_nxt_s = value_s;
                state_nxt_s = S_MASTER;
              end else begin
                state_nxt_s = S_TTIME;
              end
            end
            S_MASTER: begin
              if (pw_len_s >= 5'd4 && pw_len_s <= 5'd12) begin
                senha_nxt_s = pw_s;
                state_nxt_s = DONE;
              end else begin
                state_nxt_s = S_MASTER;
              end
            end
            default: state_nxt_s = IDLE;
          endcase
        end else begin
          state_nxt_s = state_r;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, working copy and registered outputs (outputs follow the next state)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      armed_r        <= 1'b1;
      {bip_r, btime_r, ttime_r, senha_r} <= CFG_DEFAULT;
      display_en     <= 1'b0;
      bcd_pac        <= 24'h000000;
      data_setup_new <= CFG_DEFAULT;
      data_setup_ok  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      bip_r         <= bip_nxt_s;
      btime_r       <= btime_nxt_s;
      ttime_r       <= ttime_nxt_s;
      senha_r       <= senha_nxt_s;
      // a finished menu must see setup_on low before it may be entered again
      armed_r       <= !setup_on ? 1'b1 : ((state_nxt_s == DONE) ? 1'b0 : armed_r);
      display_en    <= (state_nxt_s == S_BIP) || (state_nxt_s == S_BTIME) ||
                       (state_nxt_s == S_TTIME) || (state_nxt_s == S_MASTER);
      bcd_pac       <= make_bcd(state_nxt_s, bip_nxt_s, btime_nxt_s, ttime_nxt_s);
      data_setup_ok <= (state_nxt_s == DONE);
      if (state_nxt_s == DONE) data_setup_new <= {bip_nxt_s, btime_nxt_s, ttime_nxt_s, senha_nxt_s};
      else data_setup_new <= data_setup_new;
    end
  end

endmodule

// File: tb/tb_fechadura_setup.sv
// Bench for fechadura_setup: directed menu walks with literal expectations plus
// randomized key entries checked every cycle against a behavioural menu model.
module tb_fechadura_setup;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        setup_on = 1'b0;
  logic [79:0] digitos_value = '1;
  logic        digitos_valid = 1'b0;
  logic        display_en;
  logic [23:0] bcd_pac;
  logic [94:0] data_setup_new;
  logic        data_setup_ok;

  localparam logic [94:0] DEF = {1'b1, 7'd5, 7'd5, 80'hFFFF_FFFF_FFFF_FFFF_4321};

  int n_cmp = 0;
  int n_bad = 0;
  logic [79:0] kbuf = '1;

  // model: step 0 idle, 1..4 menu fields, 5 finishing
  int         m_step;
  bit         m_armed;
  bit         m_ok;
  int         c_bip, c_bt, c_tt, w_bip, w_bt, w_tt;
  logic [3:0] c_pw[20];
  logic [3:0] w_pw[20];

  fechadura_setup dut (
    .clk(clk), .rst(rst), .setup_on(setup_on),
    .digitos_value(digitos_value), .digitos_valid(digitos_valid),
    .display_en(display_en), .bcd_pac(bcd_pac),
    .data_setup_new(data_setup_new), .data_setup_ok(data_setup_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [94:0] act, input logic [94:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int dv(input logic [3:0] d);
    return (d > 4'd9) ? 0 : int'(d);
  endfunction

  function automatic logic [3:0] nib(input logic [79:0] b, input int k);
    return 4'(b >> (k * 4));
  endfunction

  function automatic void model_reset();
    m_step = 0; m_armed = 1; m_ok = 0;
    c_bip = 1; c_bt = 5; c_tt = 5;
    for (int i = 0; i < 20; i++) c_pw[i] = (i < 4) ? 4'(i + 1) : 4'hF;
  endfunction

  function automatic void commit();
    c_bip = w_bip; c_bt = w_bt; c_tt = w_tt; c_pw = w_pw;
    m_ok = 1; m_step = 5; m_armed = 0;
  endfunction

  function automatic void model_step(input bit on, input bit vld, input logic [79:0] b);
    int key, v, n;
    key  = int'(b[3:0]);
    m_ok = 0;
    if (m_step == 5) m_step = 0;
    else if (m_step == 0) begin
      if (on && m_armed) begin
        w_bip = c_bip; w_bt = c_bt; w_tt = c_tt; w_pw = c_pw; m_step = 1;
      end
    end
    else if (!on) m_step = 0;
    else if (vld && key == 11) commit();
    else if (vld && key == 10) begin
      v = dv(nib(b, 2)) * 10 + dv(nib(b, 1));
      if (m_step == 1 && v <= 1) begin w_bip = v; m_step = 2; end
      else if (m_step == 2 && v >= 5 && v <= 60) begin w_bt = v; m_step = 3; end
      else if (m_step == 3 && v >= 5 && v <= 60) begin w_tt = v; m_step = 4; end
      else if (m_step == 4) begin
        n = 0;
        while (n < 19 && nib(b, n + 1) != 4'hF) n++;
        if (n >= 4 && n <= 12) begin
          for (int i = 0; i < 20; i++) w_pw[i] = (i < n) ? nib(b, n - i) : 4'hF;
          commit();
        end
      end
    end
    if (!on) m_armed = 1;
  endfunction

  function automatic logic [94:0] m_cfg();
    logic [94:0] r;
    r[94] = 1'(c_bip); r[93:87] = 7'(c_bt); r[86:80] = 7'(c_tt);
    for (int i = 0; i < 20; i++) r[i*4 +: 4] = c_pw[i];
    return r;
  endfunction

  function automatic logic [23:0] m_bcd();
    int v;
    if (m_step < 1 || m_step > 4) return 24'h000000;
    if (m_step == 4) return 24'h4FFFFF;
    v = (m_step == 1) ? w_bip : (m_step == 2) ? w_bt : w_tt;
    return 24'(m_step * 32'h100000 + 32'hFFF00 + (v / 10) * 16 + v % 10);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step(setup_on, digitos_valid, digitos_value);
  end

  // Every cycle: DUT outputs against the behavioural model
  always @(negedge clk) begin
    check("display_en", 95'(display_en), 95'(m_step >= 1 && m_step <= 4));
    check("bcd_pac", 95'(bcd_pac), 95'(m_bcd()));
    check("data_setup_ok", 95'(data_setup_ok), 95'(m_ok));
    check("data_setup_new", data_setup_new, m_cfg());
  end

  task automatic press(input logic [3:0] k);
    kbuf = {kbuf[75:0], k};
    digitos_value = kbuf;
    digitos_valid = 1'b1;
    @(negedge clk);
    digitos_valid = 1'b0;
    if (k >= 4'hA) kbuf = '1;
    digitos_value = kbuf;
  endtask

  task automatic keys(input string s, input bit rnd);
    logic [3:0] k;
    for (int i = 0; i < s.len(); i++) begin
      k = (s[i] == "*") ? 4'hA : (s[i] == "#") ? 4'hB : 4'(s[i] - 8'h30);
      if (rnd) begin
        repeat ($urandom_range(2)) @(negedge clk);
        if (k >= 4'hA && $urandom_range(19) == 0) setup_on = 1'b0;
      end
      press(k);
      setup_on = 1'b1;
    end
  endtask

  task automatic reenter();
    setup_on = 1'b0;
    @(negedge clk);
    setup_on = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_entry();
    int v, len;
    bit ok;
    string s;
    ok = ($urandom_range(2) != 0);
    s  = "";
    if (m_step == 4) begin
      len = ok ? $urandom_range(4, 12) : ($urandom_range(1) ? $urandom_range(0, 3) : $urandom_range(13, 16));
      for (int i = 0; i < len; i++) s = {s, $sformatf("%0d", $urandom_range(9))};
    end else begin
      if (m_step == 1) v = ok ? $urandom_range(1) : $urandom_range(2, 99);
      else v = ok ? $urandom_range(5, 60) : ($urandom_range(1) ? $urandom_range(0, 4) : $urandom_range(61, 99));
      s = (v < 10 && $urandom_range(1) == 0) ? $sformatf("%02d", v) : $sformatf("%0d", v);
    end
    s = {s, ($urandom_range(19) == 0) ? "#" : "*"};
    keys(s, 1'b1);
  endtask

  initial begin
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_display_en", 95'(display_en), 95'(1'b0));
    check("rst_bcd5", 95'(bcd_pac[23:20]), 95'(4'h0));
    check("rst_ok", 95'(data_setup_ok), 95'(1'b0));
    check("rst_cfg", data_setup_new, DEF);
    rst = 1'b0;
    @(negedge clk);
    setup_on = 1'b1;
    @(negedge clk);
    check("enter_display_en", 95'(display_en), 95'(1'b1));
    check("enter_bcd", 95'(bcd_pac), 95'(24'h1FFF01));
    keys("#", 1'b0);
    check("exit_ok", 95'(data_setup_ok), 95'(1'b1));
    check("exit_display_en", 95'(display_en), 95'(1'b0));
    check("exit_cfg", data_setup_new, DEF);
    @(negedge clk);
    check("ok_one_cycle", 95'(data_setup_ok), 95'(1'b0));
    @(negedge clk);
    check("no_reentry", 95'(display_en), 95'(1'b0));
    reenter();
    keys("0*", 1'b0);
    check("bip_accept", 95'(bcd_pac), 95'(24'h2FFF05));
    keys("30*", 1'b0);
    check("btime_accept", 95'(bcd_pac), 95'(24'h3FFF05));
    keys("70*", 1'b0);
    check("t70_rejected", 95'(bcd_pac), 95'(24'h3FFF05));
    keys("#", 1'b0);
    check("partial_cfg", data_setup_new, {1'b0, 7'd30, 7'd5, 80'hFFFF_FFFF_FFFF_FFFF_4321});
    reenter();
    check("reenter_bcd", 95'(bcd_pac), 95'(24'h1FFF00));
    keys("1*", 1'b0);
    check("step2_shows_30", 95'(bcd_pac), 95'(24'h2FFF30));
    keys("10*20*", 1'b0);
    check("step4_bcd", 95'(bcd_pac), 95'(24'h4FFFFF));
    keys("9876*", 1'b0);
    check("full_ok", 95'(data_setup_ok), 95'(1'b1));
    check("full_cfg", data_setup_new, {1'b1, 7'd10, 7'd20, 80'hFFFF_FFFF_FFFF_FFFF_6789});
    reenter();
    keys("1*", 1'b0);
    setup_on = 1'b0;
    @(negedge clk);
    check("abort_display_en", 95'(display_en), 95'(1'b0));
    check("abort_no_ok", 95'(data_setup_ok), 95'(1'b0));
    check("abort_cfg", data_setup_new, {1'b1, 7'd10, 7'd20, 80'hFFFF_FFFF_FFFF_FFFF_6789});
    setup_on = 1'b1;
    @(negedge clk);
    keys("1", 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_display_en", 95'(display_en), 95'(1'b0));
    check("midrst_bcd", 95'(bcd_pac), 95'(24'h000000));
    check("midrst_cfg", data_setup_new, DEF);
    @(negedge clk);
    rst = 1'b0;

    for (int e = 0; e < 400; e++) begin
      r = $urandom_range(99);
      if (r < 4) begin
        setup_on = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        setup_on = 1'b1;
      end else if (r < 6) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else if (m_step < 1 || m_step > 4) begin
        if ($urandom_range(1) == 1) setup_on = 1'b0;
        @(negedge clk);
        setup_on = 1'b1;
      end else begin
        rand_entry();
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
